// File: rtl/ycr_dmem_rt_pkg.sv
// ----------------------------------------------------------------------------
// ycr_dmem_rt_pkg
// Shared types and constants for the N-port data-memory router:
//   type_ycr_mem_resp_e      - memory response encoding (NOTRDY/RDY_OK/RDY_ER)
//   ycr_dmem_rt_idw()        - port-ID width, one extra code for the error sink
//   YCR_DMEM_RT_DEF_MASK     - default per-port address mask
//   ycr_dmem_rt_def_pattern()- default packed pattern table (port i -> i<<16)
// ----------------------------------------------------------------------------
package ycr_dmem_rt_pkg;

    typedef enum logic [1:0] {
        NOTRDY = 2'd0,
        RDY_OK = 2'd1,
        RDY_ER = 2'd2
    } type_ycr_mem_resp_e;

    localparam int unsigned YCR_DMEM_RT_MAX_PORTS = 8;
    localparam int unsigned YCR_DMEM_RT_PAT_BITS  = 1024;
    localparam logic [31:0] YCR_DMEM_RT_DEF_MASK  = 32'hFFFF_0000;

    // IDs 0..port_cnt-1 are real ports, port_cnt is the error sink.
    function automatic int unsigned ycr_dmem_rt_idw(input int unsigned port_cnt);
        return $clog2(port_cnt + 1);
    endfunction

    // Wide enough for 8 ports of up to 128-bit addresses; the caller truncates.
    function automatic logic [YCR_DMEM_RT_PAT_BITS-1:0] ycr_dmem_rt_def_pattern(
        input int unsigned awidth
    );
        logic [YCR_DMEM_RT_PAT_BITS-1:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < YCR_DMEM_RT_MAX_PORTS; i++) begin
            pat = pat | ((YCR_DMEM_RT_PAT_BITS'(i) << 16) << (i * awidth));
        end
        return pat;
    endfunction

endpackage

// File: rtl/ycr_dmem_rt_idfifo.sv
// ----------------------------------------------------------------------------
// ycr_dmem_rt_idfifo
// In-order FIFO of target port IDs for outstanding router transactions.
//   clk, rst      - clock, synchronous active-high reset (clears contents)
//   push, push_id - enqueue the ID of a newly accepted request
//   pop           - dequeue the head when its response completes
//   cnt           - occupancy (0..DEPTH)
//   head_id       - ID of the oldest outstanding request
//   tail_id       - ID of the most recently pushed request
// Push and pop in the same cycle keep cnt and advance both pointers.
// ----------------------------------------------------------------------------
module ycr_dmem_rt_idfifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IDW   = 3,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [IDW-1:0] push_id,
    input  logic           pop,
    output logic [CW-1:0]  cnt,
    output logic [IDW-1:0] head_id,
    output logic [IDW-1:0] tail_id
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDW-1:0] mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  tail_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign tail_ptr = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
    assign head_id  = mem[rd_ptr];
    assign tail_id  = mem[tail_ptr];

endmodule

// File: rtl/ycr_dmem_router_np.sv
// ----------------------------------------------------------------------------
// ycr_dmem_router_np
// N-port data-memory router: decodes the core dmem request address against
// per-port mask/pattern pairs and keeps up to OUTSTD_DEPTH requests in flight,
// returning responses in order through an ID FIFO.
//   clk, rst                          - clock, synchronous active-high reset
//   dmem_req/cmd/width/addr/wdata     - core request
//   dmem_req_ack                      - request accepted (selected port's ack)
//   dmem_rdata, dmem_resp             - head transaction response
//   port_req                          - per-port request strobes
//   port_req_ack, port_rdata, port_resp - per-port target handshake
//   port_cmd/width/addr/wdata         - request fields broadcast to all ports
// Optional: YCR_DMEM_RT_DECERR_EN routes addresses matching no port (including
// port 0's own slice) to an internal sink answering RDY_ER.
// ----------------------------------------------------------------------------
module ycr_dmem_router_np
    import ycr_dmem_rt_pkg::*;
#(
    parameter int unsigned                PORT_CNT     = 4,
    parameter int unsigned                OUTSTD_DEPTH = 2,
    parameter int unsigned                AWIDTH       = 32,
    parameter int unsigned                DWIDTH       = 32,
    parameter logic [AWIDTH*PORT_CNT-1:0] ADDR_MASK    = {PORT_CNT{AWIDTH'(YCR_DMEM_RT_DEF_MASK)}},
    parameter logic [AWIDTH*PORT_CNT-1:0] ADDR_PATTERN = (AWIDTH*PORT_CNT)'(ycr_dmem_rt_def_pattern(AWIDTH))
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dmem_req,
    input  logic                       dmem_cmd,
    input  logic [1:0]                 dmem_width,
    input  logic [AWIDTH-1:0]          dmem_addr,
    input  logic [DWIDTH-1:0]          dmem_wdata,
    output logic                       dmem_req_ack,
    output logic [DWIDTH-1:0]          dmem_rdata,
    output logic [1:0]                 dmem_resp,
    output logic [PORT_CNT-1:0]        port_req,
    input  logic [PORT_CNT-1:0]        port_req_ack,
    output logic [PORT_CNT-1:0]        port_cmd,
    output logic [2*PORT_CNT-1:0]      port_width,
    output logic [AWIDTH*PORT_CNT-1:0] port_addr,
    output logic [DWIDTH*PORT_CNT-1:0] port_wdata,
    input  logic [DWIDTH*PORT_CNT-1:0] port_rdata,
    input  logic [2*PORT_CNT-1:0]      port_resp
);

    localparam int unsigned IDW = ycr_dmem_rt_idw(PORT_CNT);
    localparam int unsigned CW  = $clog2(OUTSTD_DEPTH + 1);

    logic [IDW-1:0]    sel;
    logic              hit;
    logic [IDW-1:0]    head_id;
    logic [IDW-1:0]    tail_id;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     new_cnt;
    logic [1:0]        head_resp;
    logic [DWIDTH-1:0] head_rdata;
    logic              sel_ack;
    logic              fifo_empty;
    logic              pop;
    logic              room;
    logic              same_port;
    logic              can_issue;

    // Lowest matching port among 1..PORT_CNT-1 wins.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int unsigned i = 1; i < PORT_CNT; i++) begin
            if (!hit && ((dmem_addr & ADDR_MASK[i*AWIDTH +: AWIDTH]) == ADDR_PATTERN[i*AWIDTH +: AWIDTH])) begin
                sel = IDW'(i);
                hit = 1'b1;
            end
        end
`ifdef YCR_DMEM_RT_DECERR_EN
        if (!hit && ((dmem_addr & ADDR_MASK[0 +: AWIDTH]) != ADDR_PATTERN[0 +: AWIDTH])) begin
            sel = IDW'(PORT_CNT);
        end
`endif
    end

    always_comb begin
        head_resp  = NOTRDY;
        head_rdata = '0;
        sel_ack    = 1'b0;
        for (int unsigned i = 0; i < PORT_CNT; i++) begin
            if (head_id == IDW'(i)) begin
                head_resp  = port_resp[2*i +: 2];
                head_rdata = port_rdata[DWIDTH*i +: DWIDTH];
            end
            if (sel == IDW'(i)) begin
                sel_ack = port_req_ack[i];
            end
        end
`ifdef YCR_DMEM_RT_DECERR_EN
        // Sink acks at once; its FIFO entry can only reach the head a cycle
        // later, which yields the one-cycle RDY_ER latency without extra state.
        if (head_id == IDW'(PORT_CNT)) begin
            head_resp = RDY_ER;
        end
        if (sel == IDW'(PORT_CNT)) begin
            sel_ack = 1'b1;
        end
`endif
    end

    assign fifo_empty = (cnt == '0);
    assign pop        = !fifo_empty && ((head_resp == RDY_OK) || (head_resp == RDY_ER));
    assign new_cnt    = cnt - CW'(pop);
    assign room       = (cnt < CW'(OUTSTD_DEPTH)) || pop;
    // Only the port already in flight may take new requests, so responses
    // from different targets can never overtake each other.
    assign same_port  = (new_cnt == '0) || (sel == tail_id);
    assign can_issue  = !rst && dmem_req && room && same_port;

    always_comb begin
        port_req = '0;
        for (int unsigned i = 0; i < PORT_CNT; i++) begin
            port_req[i] = can_issue && (sel == IDW'(i));
        end
    end

    assign dmem_req_ack = can_issue && sel_ack;
    assign dmem_resp    = fifo_empty ? NOTRDY : head_resp;
    assign dmem_rdata   = fifo_empty ? '0 : head_rdata;

    assign port_cmd   = {PORT_CNT{dmem_cmd}};
    assign port_width = {PORT_CNT{dmem_width}};
    assign port_addr  = {PORT_CNT{dmem_addr}};
    assign port_wdata = {PORT_CNT{dmem_wdata}};

    ycr_dmem_rt_idfifo #(
        .DEPTH (OUTSTD_DEPTH),
        .IDW   (IDW),
        .CW    (CW)
    ) u_idfifo (
        .clk     (clk),
        .rst     (rst),
        .push    (dmem_req_ack),
        .push_id (sel),
        .pop     (pop),
        .cnt     (cnt),
        .head_id (head_id),
        .tail_id (tail_id)
    );

endmodule
